// File: rtl/unified_mem_responder.sv
// Block memory shared by an instruction port and a data port. One transaction is in
// flight at a time, and each transaction answers a fixed LATENCY cycles after acceptance.
module unified_mem_responder #(
  parameter int BLOCK_BITS = 128,
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  imem_ren,
  input  logic [ADDR_BITS-1:0]  imem_block_address,
  output logic                  imem_ready,
  output logic [BLOCK_BITS-1:0] imem_dout,
  input  logic                  dmem_ren,
  input  logic                  dmem_wen,
  input  logic [ADDR_BITS-1:0]  dmem_block_address,
  input  logic [BLOCK_BITS-1:0] dmem_din,
  output logic                  dmem_ready,
  output logic                  dmem_done,
  output logic [BLOCK_BITS-1:0] dmem_dout,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  port_d_p0;
  logic                  op_wr_p0;
  logic [ADDR_BITS-1:0]  addr_p0;
  logic [BLOCK_BITS-1:0] din_p0;
  logic [BLOCK_BITS-1:0] mem [DEPTH];

  logic                  d_req;
  logic                  accept;
  logic                  resp_now;
  logic                  sel_d;
  logic                  sel_wr;
  logic [ADDR_BITS-1:0]  sel_addr;

  // With LATENCY==1 the response is produced on the acceptance edge, so the
  // response fields come straight from the ports instead of the latched copies.
  always_comb begin
    d_req    = dmem_ren | dmem_wen;
    accept   = (state == IDLE) && (d_req || imem_ren);
    resp_now = (accept && (LATENCY == 1)) || ((state == BUSY) && (count == 4'd1));
    if (state == IDLE) begin
      sel_d    = d_req;
      sel_wr   = dmem_wen;
      sel_addr = d_req ? dmem_block_address : imem_block_address;
    end else begin
      sel_d    = port_d_p0;
      sel_wr   = op_wr_p0;
      sel_addr = addr_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      busy       <= 1'b0;
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_done  <= 1'b0;
      imem_dout  <= '0;
      dmem_dout  <= '0;
    end else begin
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            port_d_p0 <= d_req;
            op_wr_p0  <= dmem_wen;
            addr_p0   <= sel_addr;
            din_p0    <= dmem_din;
            count     <= LAT_M1;
            busy      <= 1'b1;
            state     <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // response pulses are registered so they are high during the RESP cycle
      if (resp_now) begin
        if (sel_wr) begin
          dmem_done <= 1'b1;
        end else if (sel_d) begin
          dmem_ready <= 1'b1;
          dmem_dout  <= mem[sel_addr];
        end else begin
          imem_ready <= 1'b1;
          imem_dout  <= mem[sel_addr];
        end
      end
    end
  end

  // Writes commit on leaving RESP, so a reset during RESP still cancels them.
  always_ff @(posedge clock) begin
    if (reset && (state == RESP) && op_wr_p0) mem[addr_p0] <= din_p0;
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized bench for unified_mem_responder: a word-array reference model with
// arithmetic response timing, plus directed arbitration, reset-abort and LATENCY=1 cases.
module tb_unified_mem_responder;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         i_ren, d_ren, d_wen;
  logic [9:0]   i_addr, d_addr;
  logic [127:0] d_din;
  logic         i_rdy, d_rdy, d_done, busy0;
  logic [127:0] i_dout, d_dout;

  logic         i1_ren, d1_ren, d1_wen;
  logic [9:0]   i1_addr, d1_addr;
  logic [127:0] d1_din;
  logic         i1_rdy, d1_rdy, d1_done, busy1;
  logic [127:0] i1_dout, d1_dout;

  unified_mem_responder #(.BLOCK_BITS(128), .ADDR_BITS(10), .LATENCY(LAT)) u_dut (
    .clock(clk), .reset(rst_n),
    .imem_ren(i_ren), .imem_block_address(i_addr), .imem_ready(i_rdy), .imem_dout(i_dout),
    .dmem_ren(d_ren), .dmem_wen(d_wen), .dmem_block_address(d_addr), .dmem_din(d_din),
    .dmem_ready(d_rdy), .dmem_done(d_done), .dmem_dout(d_dout), .busy(busy0)
  );

  unified_mem_responder #(.BLOCK_BITS(128), .ADDR_BITS(10), .LATENCY(1)) u_dut1 (
    .clock(clk), .reset(rst_n),
    .imem_ren(i1_ren), .imem_block_address(i1_addr), .imem_ready(i1_rdy), .imem_dout(i1_dout),
    .dmem_ren(d1_ren), .dmem_wen(d1_wen), .dmem_block_address(d1_addr), .dmem_din(d1_din),
    .dmem_ready(d1_rdy), .dmem_done(d1_done), .dmem_dout(d1_dout), .busy(busy1)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [127:0] mdl [64];
  logic [127:0] last_id, last_dd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_ren = 1'b0;
    d_ren = 1'b0;
    d_wen = 1'b0;
  endtask

  // mode 0: hold request until response, 1: drop after acceptance, 2: scramble after acceptance
  task automatic txn(input bit is_d, input bit wr, input bit rd_too, input logic [5:0] a,
                     input logic [127:0] din, input int mode);
    logic [127:0] exp_rd;
    exp_rd = mdl[a];
    if (is_d) begin
      d_ren  = !wr || rd_too;
      d_wen  = wr;
      d_addr = {4'd0, a};
      d_din  = din;
    end else begin
      i_ren  = 1'b1;
      i_addr = {4'd0, a};
    end
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 1 && mode == 1) idle_inputs();
      if (k == 1 && mode == 2) begin
        d_addr = 10'($urandom);
        d_din  = rnd128();
        i_addr = 10'($urandom);
      end
      if (k == LAT) begin
        if (is_d && wr) mdl[a] = din;
        else if (is_d) last_dd = exp_rd;
        else last_id = exp_rd;
      end
      chk("busy", 128'(busy0), 128'(1'b1));
      chk("imem_ready", 128'(i_rdy), 128'(k == LAT && !is_d));
      chk("dmem_ready", 128'(d_rdy), 128'(k == LAT && is_d && !wr));
      chk("dmem_done", 128'(d_done), 128'(k == LAT && is_d && wr));
      chk("imem_dout", i_dout, last_id);
      chk("dmem_dout", d_dout, last_dd);
    end
    idle_inputs();
    tick();
    chk("busy_after", 128'(busy0), 128'(1'b0));
    chk("pulses_after", 128'({i_rdy, d_rdy, d_done}), 128'(3'b000));
  endtask

  initial begin
    logic [127:0] va, vb;
    bit is_d, wr;
    rst_n = 1'b0;
    idle_inputs();
    i_addr = '0; d_addr = '0; d_din = '0;
    i1_ren = 1'b0; d1_ren = 1'b0; d1_wen = 1'b0;
    i1_addr = '0; d1_addr = '0; d1_din = '0;
    last_id = '0; last_dd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy0), 128'(1'b0));
    chk("rst_pulses", 128'({i_rdy, d_rdy, d_done}), 128'(3'b000));
    chk("rst_imem_dout", i_dout, '0);
    chk("rst_dmem_dout", d_dout, '0);
    chk("rst_dout_l1", d1_dout, '0);

    // first request issued in the first cycle with reset high
    rst_n = 1'b1;
    for (int a = 0; a < 64; a++) txn(1'b1, 1'b1, 1'b0, 6'(a), rnd128(), 0);

    txn(1'b1, 1'b1, 1'b0, 6'h05, 128'hDEADBEEF_00000001_CAFEF00D_12345678, 0);
    txn(1'b1, 1'b0, 1'b0, 6'h05, '0, 0);
    chk("wr_rd_0x005", d_dout, 128'hDEADBEEF_00000001_CAFEF00D_12345678);

    txn(1'b1, 1'b1, 1'b1, 6'h20, 128'h1, 0);
    txn(1'b1, 1'b0, 1'b0, 6'h20, '0, 0);
    chk("wr_and_rd_0x020", d_dout, 128'h1);

    // simultaneous imem/dmem: data side first, imem accepted in the IDLE cycle after
    d_ren = 1'b1; d_addr = 10'h006; i_ren = 1'b1; i_addr = 10'h005;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) begin d_ren = 1'b0; last_dd = mdl[6]; end
      if (k == 9) last_id = mdl[5];
      chk("arb_busy", 128'(busy0), 128'(k != 5));
      chk("arb_dmem_ready", 128'(d_rdy), 128'(k == 4));
      chk("arb_imem_ready", 128'(i_rdy), 128'(k == 9));
      chk("arb_done", 128'(d_done), 128'(1'b0));
      chk("arb_dmem_dout", d_dout, last_dd);
      chk("arb_imem_dout", i_dout, last_id);
    end
    idle_inputs();
    tick();
    chk("arb_idle", 128'({busy0, i_rdy, d_rdy}), 128'(3'b000));

    for (int n = 0; n < 80; n++) begin
      is_d = ($urandom % 3) != 0;
      wr   = is_d && ($urandom % 2 == 1);
      txn(is_d, wr, wr && ($urandom % 4 == 0), 6'($urandom), rnd128(), int'($urandom % 3));
    end

    // reset two cycles after acceptance aborts the read
    d_ren = 1'b1; d_addr = 10'h010;
    tick();
    tick();
    rst_n = 1'b0;
    d_ren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) rst_n = 1'b1;
      chk("abort_busy", 128'(busy0), 128'(1'b0));
      chk("abort_pulses", 128'({i_rdy, d_rdy, d_done}), 128'(3'b000));
      chk("abort_dmem_dout", d_dout, '0);
      chk("abort_imem_dout", i_dout, '0);
    end
    last_id = '0; last_dd = '0;
    txn(1'b1, 1'b0, 1'b0, 6'h10, '0, 0);
    chk("post_reset_0x010", d_dout, mdl[6'h10]);

    // LATENCY=1 instance: back-to-back reads two cycles apart
    va = rnd128(); vb = rnd128();
    d1_wen = 1'b1; d1_addr = 10'h000; d1_din = va;
    tick();
    chk("l1_done0", 128'({d1_done, busy1}), 128'(2'b11));
    d1_wen = 1'b0;
    tick();
    chk("l1_idle0", 128'({d1_done, busy1}), 128'(2'b00));
    d1_wen = 1'b1; d1_addr = 10'h001; d1_din = vb;
    tick();
    chk("l1_done1", 128'(d1_done), 128'(1'b1));
    d1_wen = 1'b0;
    tick();
    d1_ren = 1'b1; d1_addr = 10'h000;
    tick();
    chk("l1_rdy_a", 128'(d1_rdy), 128'(1'b1));
    chk("l1_dout_a", d1_dout, va);
    d1_addr = 10'h001;
    tick();
    chk("l1_gap", 128'({d1_rdy, busy1}), 128'(2'b00));
    chk("l1_hold_a", d1_dout, va);
    tick();
    chk("l1_rdy_b", 128'(d1_rdy), 128'(1'b1));
    chk("l1_dout_b", d1_dout, vb);
    d1_ren = 1'b0;
    tick();
    chk("l1_end", 128'({d1_rdy, d1_done, i1_rdy}), 128'(3'b000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
